// File: rtl/m68k_bus_target.sv
//------------------------------------------------------------------------------
// m68k_bus_target : oversampling 68000 bus responder with req/ack backend port
// Revision        : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module m68k_bus_target #(
  parameter logic [23:0] BASE        = 24'hE80000,
  parameter logic [23:0] MASK        = 24'hFF0000,
  parameter int          WAIT_STATES = 0,
  parameter int          TIMEOUT     = 255
) (
  input  logic        c200m,
  input  logic        rst,
  input  logic [22:0] M68K_A,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic        be_req,
  output logic        be_we,
  output logic [22:0] be_addr,
  output logic [1:0]  be_be,
  output logic [15:0] be_wdata,
  input  logic        be_ack,
  input  logic [15:0] be_rdata,
  output logic        busy
);

  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0]  WS_LAST  = 4'(WAIT_STATES - 1);
  localparam logic [23:0] CMP_MASK = MASK & 24'hFFFFFE;

  typedef enum logic [2:0] {
    S_IDLE, S_WAITDS, S_ACCESS, S_WAIT, S_ACK, S_ERR, S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic        as_s1, as_s2, as_s3;
  logic        uds_s1, uds_s2, lds_s1, lds_s2, rw_s1, rw_s2;
  logic [22:0] a_s1, a_s2;
  logic [15:0] din_s1, din_s2;

  logic [7:0]  tcnt;
  logic [3:0]  wcnt;
  logic        aborted;

  logic as_fall, as_rise, hit, timed_out;
  logic latch_cyc, start_req, take_data, drop_req;

  // Bus pins are asynchronous to c200m; idle bus is all ones.
  always_ff @(posedge c200m) begin
    if (rst) begin
      as_s1 <= 1'b1; as_s2 <= 1'b1; as_s3 <= 1'b1;
      uds_s1 <= 1'b1; uds_s2 <= 1'b1;
      lds_s1 <= 1'b1; lds_s2 <= 1'b1;
      rw_s1 <= 1'b1; rw_s2 <= 1'b1;
      a_s1 <= '1; a_s2 <= '1;
      din_s1 <= '1; din_s2 <= '1;
    end else begin
      as_s1 <= M68K_AS_n;   as_s2 <= as_s1;   as_s3 <= as_s2;
      uds_s1 <= M68K_UDS_n; uds_s2 <= uds_s1;
      lds_s1 <= M68K_LDS_n; lds_s2 <= lds_s1;
      rw_s1 <= M68K_RW;     rw_s2 <= rw_s1;
      a_s1 <= M68K_A;       a_s2 <= a_s1;
      din_s1 <= M68K_D_IN;  din_s2 <= din_s1;
    end
  end

  assign as_fall   = as_s3 & ~as_s2;
  assign as_rise   = ~as_s3 & as_s2;
  assign hit       = ((({a_s2, 1'b0}) ^ BASE) & CMP_MASK) == 24'd0;
  assign timed_out = (tcnt == TO_LAST);

  always_comb begin
    state_nx  = state;
    latch_cyc = 1'b0;
    start_req = 1'b0;
    take_data = 1'b0;
    drop_req  = 1'b0;
    case (state)
      S_IDLE: begin
        if (as_fall && hit) begin
          state_nx  = S_WAITDS;
          latch_cyc = 1'b1;
        end
      end
      S_WAITDS: begin
        if (as_rise) begin
          state_nx = S_IDLE;
        end else if (!uds_s2 || !lds_s2) begin
          state_nx  = S_ACCESS;
          start_req = 1'b1;
        end else if (timed_out) begin
          state_nx = S_ERR;
        end
      end
      S_ACCESS: begin
        // An ack in the timeout cycle still completes the cycle normally.
        if (be_ack) begin
          drop_req = 1'b1;
          if (aborted || as_rise) begin
            state_nx = S_IDLE;
          end else begin
            take_data = 1'b1;
            state_nx  = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
          end
        end else if (timed_out) begin
          state_nx = S_ERR;
        end
      end
      S_WAIT: begin
        if (as_rise)               state_nx = S_IDLE;
        else if (wcnt == WS_LAST)  state_nx = S_ACK;
        else if (timed_out)        state_nx = S_ERR;
      end
      S_ACK: begin
        if (as_rise) state_nx = S_IDLE;
      end
      S_ERR: begin
        if (be_req && be_ack) drop_req = 1'b1;
        // A cycle aborted before the timeout has already seen its AS rise.
        if (as_rise || aborted)
          state_nx = (be_req && !be_ack) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (be_ack) begin
          drop_req = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge c200m) begin
    if (rst) begin
      state        <= S_IDLE;
      tcnt         <= '0;
      wcnt         <= '0;
      aborted      <= 1'b0;
      be_req       <= 1'b0;
      be_we        <= 1'b0;
      be_addr      <= '0;
      be_be        <= '0;
      be_wdata     <= '0;
      M68K_D_OUT   <= '0;
      M68K_D_OE    <= 1'b0;
      M68K_DTACK_n <= 1'b1;
      M68K_BERR_n  <= 1'b1;
    end else begin
      state        <= state_nx;
      // Strobes drop in the same cycle the release is seen.
      M68K_DTACK_n <= !(state == S_ACK && !as_rise);
      M68K_D_OE    <= (state == S_ACK) && !as_rise && !be_we;
      M68K_BERR_n  <= (state_nx != S_ERR);

      if (latch_cyc) begin
        be_addr <= a_s2;
        be_we   <= ~rw_s2;
        tcnt    <= '0;
        aborted <= 1'b0;
      end else if (state inside {S_WAITDS, S_ACCESS, S_WAIT}) begin
        tcnt <= tcnt + 8'd1;
      end

      if (state == S_ACCESS && as_rise) aborted <= 1'b1;

      if (state == S_WAIT) wcnt <= wcnt + 4'd1;
      else                 wcnt <= '0;

      if (start_req) begin
        be_req   <= 1'b1;
        be_be    <= {~uds_s2, ~lds_s2};
        be_wdata <= din_s2;
      end
      if (drop_req)  be_req     <= 1'b0;
      if (take_data) M68K_D_OUT <= be_rdata;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

`default_nettype wire
